// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings for the writeback stage
package wb_pkg;

  typedef enum logic [1:0] {
    WB_PC  = 2'd0,
    WB_ALU = 2'd1,
    WB_MEM = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - upstream op, memory return and register-file write signals
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_wb_sel;
  logic            in_rd_we;
  logic [4:0]      in_rd_addr;
  logic [XLEN-1:0] in_pc_next;
  logic [XLEN-1:0] in_result;
  logic [XLEN-1:0] in_imm_x;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic            load_err;

  modport slave (
    input  in_valid, in_wb_sel, in_rd_we, in_rd_addr, in_pc_next, in_result,
           in_imm_x, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, busy, load_err
  );

  modport master (
    output in_valid, in_wb_sel, in_rd_we, in_rd_addr, in_pc_next, in_result,
           in_imm_x, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, busy, load_err
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - byte/half/word extraction and sign/zero extension of load data
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      // LW and the unused codes return the raw word
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered, handshaked RV32I writeback stage with load wait and timeout
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16,
  parameter int TMO_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              rd_we_q, rd_we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              load_err_q, load_err_d;

  logic              accept;
  logic              is_load;
  logic              timeout_hit;
  logic [XLEN-1:0]   load_data;

  assign accept      = bus.in_valid && (state_q == IDLE);
  assign is_load     = (bus.in_wb_sel == WB_MEM);
  // A zero timeout disables the abort entirely
  assign timeout_hit = (LOAD_TIMEOUT != 0) && (cnt_q == TMO_W'(LOAD_TIMEOUT - 1));

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (bus.mem_rdata),
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rd_we_q    <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_we_q    <= rd_we_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_load) state_d = WAIT_LOAD;
      WAIT_LOAD: if (bus.mem_rvalid || timeout_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_we_d    = rd_we_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_addr_d = bus.in_rd_addr;
          rd_we_d   = bus.in_rd_we;
          funct3_d  = bus.in_funct3;
          addr_lo_d = bus.in_addr_lo;
          cnt_d     = '0;
          if (!is_load) begin
            rf_we_d    = bus.in_rd_we && (bus.in_rd_addr != 5'd0);
            rf_waddr_d = bus.in_rd_addr;
            case (bus.in_wb_sel)
              WB_PC:   rf_wdata_d = bus.in_pc_next;
              WB_ALU:  rf_wdata_d = bus.in_result;
              default: rf_wdata_d = bus.in_imm_x;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        // Data arriving in the final counted cycle beats the timeout
        if (bus.mem_rvalid) begin
          rf_we_d    = rd_we_q && (rd_addr_q != 5'd0);
          rf_waddr_d = rd_addr_q;
          rf_wdata_d = load_data;
        end else if (timeout_hit) begin
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == WAIT_LOAD);
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.load_err = load_err_q;

endmodule
